// File: rtl/alu_issue_pkg.sv
// Shared types for the RV32I decode-to-execute issue stage.
// ALU_ISSUE_ILLEGAL_EN adds an illegal-encoding flag to each issue entry.
package alu_issue_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_SRA  = 4'd13
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        alu_op_e           alu_ctrl;
        logic [4:0]        rd;
        logic              rd_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic              illegal;
`endif
    } issue_entry_t;

endpackage

// File: rtl/issue_skid_buf.sv
// Two-entry valid/ready skid buffer over issue_entry_t (head + one skid slot).
// Handshake flags and the head entry are all registered; flush drops both slots.
module issue_skid_buf
    import alu_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  issue_entry_t in_entry,
    output logic         out_valid,
    input  logic         out_ready,
    output issue_entry_t out_entry
);

    buf_state_e   state_r, state_s;
    issue_entry_t head_r, head_s;
    issue_entry_t skid_r, skid_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         accept_s;
    logic         retire_s;

    // Occupancy transitions; the head always holds the oldest entry.
    always_comb begin
        state_s  = state_r;
        head_s   = head_r;
        skid_s   = skid_r;
        accept_s = in_valid && in_ready_r;
        retire_s = out_valid_r && out_ready;
        if (flush) begin
            state_s = BUF_EMPTY;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        head_s  = in_entry;
                        state_s = BUF_ONE;
                    end else begin
                        state_s = BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && retire_s) begin
                        head_s = in_entry;
                    end else if (accept_s) begin
                        skid_s  = in_entry;
                        state_s = BUF_FULL;
                    end else if (retire_s) begin
                        state_s = BUF_EMPTY;
                    end else begin
                        state_s = BUF_ONE;
                    end
                end
                BUF_FULL: begin
                    if (retire_s) begin
                        head_s  = skid_r;
                        state_s = BUF_ONE;
                    end else begin
                        state_s = BUF_FULL;
                    end
                end
                default: begin
                    state_s = BUF_EMPTY;
                end
            endcase
        end
    end

    // State and handshake registers; flags are precomputed from next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= BUF_EMPTY;
            head_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != BUF_FULL);
            out_valid_r <= (state_s != BUF_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_entry = head_r;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes an instruction into ALU operands/control and
// buffers it toward execute. ALU_ISSUE_ILLEGAL_EN exposes out_illegal.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [3:0]      out_alu_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_rd_we
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    logic [6:0]   opcode_s;
    logic [2:0]   f3_s;
    logic [6:0]   f7_s;
    logic [4:0]   rd_s;
    logic [31:0]  i_imm_s;
    logic [31:0]  s_imm_s;
    logic [31:0]  u_imm_s;
    logic         illegal_s;
    logic         writes_s;
    issue_entry_t entry_s;
    issue_entry_t head_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign f3_s     = in_instr[14:12];
    assign f7_s     = in_instr[31:25];
    assign i_imm_s  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign s_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign u_imm_s  = {in_instr[31:12], 12'h000};

    // Decode; illegal encodings collapse to an all-zero ADD with no writeback.
    always_comb begin
        entry_s          = '0;
        entry_s.rd       = rd_s;
        entry_s.alu_ctrl = ALU_ADD;
        illegal_s        = 1'b0;
        writes_s         = 1'b1;
        case (opcode_s)
            OPC_OP: begin
                entry_s.op1 = in_rs1_data;
                entry_s.op2 = in_rs2_data;
                if (f7_s == 7'b0000000) begin
                    entry_s.alu_ctrl = alu_op_e'({1'b0, f3_s});
                end else if ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
                    entry_s.alu_ctrl = alu_op_e'({1'b1, f3_s});
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                entry_s.op1 = in_rs1_data;
                if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
                    entry_s.op2 = {27'd0, in_instr[24:20]};
                end else begin
                    entry_s.op2 = i_imm_s;
                end
                entry_s.alu_ctrl = alu_op_e'({(f3_s == 3'b101) ? f7_s[5] : 1'b0, f3_s});
            end
            OPC_LUI: begin
                entry_s.op2 = u_imm_s;
            end
            OPC_AUIPC: begin
                entry_s.op1 = in_pc;
                entry_s.op2 = u_imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                entry_s.op1 = in_pc;
                entry_s.op2 = 32'd4;
            end
            OPC_LOAD: begin
                entry_s.op1 = in_rs1_data;
                entry_s.op2 = i_imm_s;
            end
            OPC_STORE: begin
                entry_s.op1 = in_rs1_data;
                entry_s.op2 = s_imm_s;
                writes_s    = 1'b0;
            end
            OPC_BRANCH: begin
                entry_s.op1 = in_rs1_data;
                entry_s.op2 = in_rs2_data;
                writes_s    = 1'b0;
                case (f3_s)
                    3'b000, 3'b001: entry_s.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: entry_s.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: entry_s.alu_ctrl = ALU_SLTU;
                    default:        illegal_s = 1'b1;
                endcase
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        if (illegal_s) begin
            entry_s = '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            entry_s.illegal = 1'b1;
`endif
        end else begin
            entry_s.rd_we = writes_s && (rd_s != 5'd0);
        end
    end

    issue_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (entry_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (head_s)
    );

    assign out_op1      = head_s.op1;
    assign out_op2      = head_s.op2;
    assign out_alu_ctrl = head_s.alu_ctrl;
    assign out_rd       = head_s.rd;
    assign out_rd_we    = head_s.rd_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal  = head_s.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed spec cases plus random traffic
// checked against an instruction-level reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_rs1_data = 32'd0;
    logic [31:0] in_rs2_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal_w;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .out_illegal  (out_illegal_w)
`endif
    );
`ifndef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal_w = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the ISA says the execute stage should see for this instruction.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] immi = 32'($signed(ins[31:20]));
        logic [31:0] imms = 32'($signed({ins[31:25], ins[11:7]}));
        logic        bad = 1'b0;
        e = '0;
        e.rd = ins[11:7];
        e.we = 1'b1;
        case (opc)
            7'h33: begin
                e.op1 = a; e.op2 = b;
                if (f7 == 7'h00) e.ctrl = 4'(f3);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.ctrl = 4'(f3) + 4'd8;
                else bad = 1'b1;
            end
            7'h13: begin
                e.op1 = a;
                e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : immi;
                e.ctrl = 4'(f3) + ((f3 == 3'd5 && ins[30]) ? 4'd8 : 4'd0);
            end
            7'h37: begin e.op1 = 32'd0; e.op2 = ins & 32'hFFFFF000; end
            7'h17: begin e.op1 = pc; e.op2 = ins & 32'hFFFFF000; end
            7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; end
            7'h03: begin e.op1 = a; e.op2 = immi; end
            7'h23: begin e.op1 = a; e.op2 = imms; e.we = 1'b0; end
            7'h63: begin
                e.op1 = a; e.op2 = b; e.we = 1'b0;
                if (f3 < 3'd2) e.ctrl = 4'd8;
                else if (f3 >= 3'd6) e.ctrl = 4'd3;
                else if (f3 >= 3'd4) e.ctrl = 4'd2;
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            e.ill = 1'b1;
`endif
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
        logic [31:0] w = $urandom();
        int          sel = $urandom_range(0, 10);
        if (sel < 9) w[6:0] = ops[sel];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) w[31:25] = 7'h00;
            else if (sel == 1) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; an accepted instruction is booked in the scoreboard.
    task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy, input logic fl);
        in_valid = v; in_instr = ins; in_pc = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
        in_rs1_data = a; in_rs2_data = b; out_ready = rdy; flush = fl;
        if (v && in_ready && !fl && rst_n) sbq.push_back(model(ins, in_pc, a, b));
    endtask

    // Monitor: occupancy, head contents and retirement against the scoreboard.
    always @(negedge clk) begin
        int   base;
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            base = sbq.size() - ((in_valid && in_ready && !flush) ? 1 : 0);
            check("mon_valid", 32'(out_valid), 32'(base > 0));
            check("mon_ready", 32'(in_ready), 32'(base < 2));
            if (out_valid && base > 0) begin
                e = sbq[0];
                check("mon_op1", out_op1, e.op1);
                check("mon_op2", out_op2, e.op2);
                check("mon_ctrl", 32'(out_alu_ctrl), 32'(e.ctrl));
                check("mon_rd", 32'(out_rd), 32'(e.rd));
                check("mon_we", 32'(out_rd_we), 32'(e.we));
                check("mon_ill", 32'(out_illegal_w), 32'(e.ill));
            end
            if (flush) sbq.delete();
            else if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
        end
    end

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_op1", out_op1, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_ctrl", 32'(out_alu_ctrl), 32'd0);

        cyc(); put(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_op1", out_op1, 32'd5);
        check("add_op2", out_op2, 32'd7);
        check("add_ctrl", 32'(out_alu_ctrl), 32'd0);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_we", 32'(out_rd_we), 32'd1);

        cyc(); put(1'b1, 32'h40335293, 32'h80000000, 32'd0, 1'b1, 1'b0);
        cyc(); put(1'b1, 32'h403100B3, 32'd9, 32'd4, 1'b1, 1'b0);
        @(negedge clk);
        check("srai_ctrl", 32'(out_alu_ctrl), 32'd13);
        check("srai_op2", out_op2, 32'd3);
        cyc(); put(1'b1, 32'h123450B7, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("sub_ctrl", 32'(out_alu_ctrl), 32'd8);
        cyc(); put(1'b1, 32'h0020E463, 32'd1, 32'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("lui_op1", out_op1, 32'd0);
        check("lui_op2", out_op2, 32'h12345000);
        check("lui_ctrl", 32'(out_alu_ctrl), 32'd0);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("bltu_ctrl", 32'(out_alu_ctrl), 32'd3);
        check("bltu_we", 32'(out_rd_we), 32'd0);

        // Back-pressure: two entries fill the stage, then drain in order.
        cyc(); put(1'b1, 32'h01100093, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); put(1'b1, 32'h02200113, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_head", out_op2, 32'h11);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("drain_a", out_op2, 32'h11);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("drain_b", out_op2, 32'h22);
        check("drain_ready", 32'(in_ready), 32'd1);

        // Flush while full with a simultaneous input.
        cyc(); put(1'b1, 32'h01100093, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); put(1'b1, 32'h02200113, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); put(1'b1, 32'h03300193, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);

        // Reset mid-stream.
        cyc(); put(1'b1, 32'h01100093, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); put(1'b1, 32'h02200113, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); rst_n = 1'b0; put(1'b1, 32'h03300193, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); rst_n = 1'b1; put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_op2", out_op2, 32'd0);

        cyc(); put(1'b1, 32'hFFFFFFFF, 32'd3, 32'd4, 1'b1, 1'b0);
        cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("ill_we", 32'(out_rd_we), 32'd0);
        check("ill_ctrl", 32'(out_alu_ctrl), 32'd0);
        check("ill_op1", out_op1, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check("ill_flag", 32'(out_illegal_w), 32'd1);
`else
        check("ill_rd", 32'(out_rd), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            cyc();
            rst_n = ($urandom_range(0, 199) != 0);
            put(($urandom_range(0, 9) < 7), rand_instr(), $urandom(), $urandom(),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        @(negedge clk);
        check("drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
